red_pitaya_xadc_drp_ctrl: RTL and testbench
===========================================

// Module: red_pitaya_xadc_drp_ctrl
// PURPOSE
//  Owns the XADC DRP port. Shares it between sequencer readback (one DRP read per
//  EOC, addr = CHANNEL) and single DRP read/write requests from SW (already in clk_i domain).
//  Emits readback samples as chan+data+strobe for the AMS register file and streaming users.
//  Adds a DRDY timeout and an EOC overrun flag.
// PARAMETERS
//  TIMEOUT_CYC  64  clk_i cycles after DEN without DRDY before the transaction is abandoned
//  SMP_BITS     12  sample width; smp_data_o = drp_do_i[15:16-SMP_BITS]
// PORTS
//  clk_i          in   1   clock (XADC DCLK domain)
//  rst_i          in   1   synchronous, active-high reset
//  xadc_eoc_i     in   1   XADC EOC pulse
//  xadc_chan_i    in   5   XADC CHANNEL, valid with EOC
//  drp_addr_o     out  7   DRP DADDR
//  drp_en_o       out  1   DRP DEN, one-cycle pulse
//  drp_we_o       out  1   DRP DWE, qualified by drp_en_o
//  drp_di_o       out  16  DRP DI
//  drp_do_i       in   16  DRP DO
//  drp_drdy_i     in   1   DRP DRDY
//  sw_req_i       in   1   SW request; level, held with fields stable until sw_done_o
//  sw_we_i        in   1   1 = write, 0 = read
//  sw_addr_i      in   7   SW DRP address
//  sw_wdata_i     in   16  SW write data
//  sw_done_o      out  1   one-cycle completion pulse
//  sw_rdata_o     out  16  read data, valid with sw_done_o, held until next done
//  sw_err_o       out  1   with sw_done_o: transaction timed out
//  smp_valid_o    out  1   one-cycle sample strobe
//  smp_chan_o     out  5   sample channel
//  smp_data_o     out  SMP_BITS  sample value
//  ovr_o          out  1   sticky: EOC lost (pending slot overwritten) or auto timeout
//  ovr_clr_i      in   1   clears ovr_o; a same-cycle set wins
// BEHAVIOUR
//  Reset: state IDLE, pending cleared, last_sw = 0; every output 0.
//  States IDLE, AUTO_WAIT, SW_WAIT. All outputs registered.
//  Pending slot: EOC sets pend = 1 and pend_chan = xadc_chan_i in any state.
//   EOC while pend = 1: overwrite pend_chan and set ovr_o.
//   In IDLE, the same-cycle EOC is eligible for grant, i.e. zero-wait.
//  Arbitration in IDLE:
//   Both pend and sw_req_i: grant SW if last_sw = 0, else AUTO (round-robin).
//   Single requester: grant it.
//   last_sw = 1 after a SW grant; last_sw = 0 after an AUTO grant.
//  Grant at cycle T: at T+1, drp_en_o = 1 for exactly one cycle with addr/we/di.
//   AUTO grant: addr = {2'b0, pend_chan}, we = 0; pend cleared at grant.
//   An EOC in the grant cycle re-arms pend.
//  WAIT: counter starts at 0 at the DEN cycle.
//   DRDY in AUTO_WAIT: next cycle smp_valid_o = 1, chan and data latched; go to IDLE.
//   DRDY in SW_WAIT: next cycle sw_done_o = 1, sw_err_o = 0, sw_rdata_o = drp_do_i
//    (written back unchanged for writes); go to IDLE.
//   Counter reaches TIMEOUT_CYC - 1 without DRDY:
//    SW: sw_done_o = 1, sw_err_o = 1, sw_rdata_o = 16'h0.
//    AUTO: no sample; set ovr_o.
//    Either way go to IDLE.
//  DRDY in IDLE (stray/late) is ignored. No new grant in the cycle DRDY is consumed.
//   Earliest re-issue is DEN two cycles after DRDY.
//  sw_req_i must drop the cycle after sw_done_o. Still high in IDLE => a new request.
//  Reset mid-transaction: abandon immediately, no done/valid pulse; a late DRDY is ignored.
//  Sample extraction truncates, no rounding. smp_chan_o = 5-bit channel, not the 7-bit address.
// STRUCTURE
//  Package red_pitaya_xadc_pkg:
//   state enum
//   DRP channel constants: TEMP=0 VCCINT=1 VCCAUX=2 VPVN=3 VCCBRAM=6 VCCPINT=13
//    VCCPAUX=14 VCCDDR=15 VAUX0=16 VAUX1=17 VAUX8=24 VAUX9=25
//   config register addresses 0x40-0x42
//  Single module; timeout counter and pending slot inline, no sub-module.
// TESTING
//  1 EOC chan 24, DRDY 3 cycles after DEN, DO=16'hABC0
//    -> smp_valid_o pulse, smp_chan_o=24, smp_data_o=12'hABC, ovr_o=0.
//  2 SW read addr 7'h41, DO=16'h2F0F
//    -> DEN addr 7'h41 we=0; sw_done_o pulse, sw_rdata_o=16'h2F0F, sw_err_o=0.
//  3 EOC chan 16 and sw_req_i in same IDLE cycle, last_sw=0
//    -> SW served first, then auto read addr 7'd16; next contention grants AUTO.
//  4 Two EOCs (chan 16 then 17) during one SW_WAIT
//    -> single auto read of addr 17; ovr_o=1; ovr_clr_i pulse clears it.
//  5 SW write addr 7'h40 data 16'h0000, no DRDY
//    -> sw_done_o at DEN+64, sw_err_o=1, sw_rdata_o=0.
//    -> DRDY injected afterwards in IDLE is ignored.
//  6 rst_i during AUTO_WAIT, then DRDY -> no smp_valid_o; all outputs 0; pend=0.

Source files
------------

// File: rtl/red_pitaya_xadc_pkg.sv
// Shared XADC DRP definitions: controller states, sequencer channel numbers,
// configuration register addresses and the channel-to-DRP-address mapping.
// Pure declarations: no logic, no latency, no flow control.
package red_pitaya_xadc_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_AUTO_WAIT = 2'd1;
  localparam logic [1:0] ST_SW_WAIT   = 2'd2;

  // Sequencer CHANNEL codes; each is also the DRP status register address
  localparam logic [4:0] CH_TEMP    = 5'd0;
  localparam logic [4:0] CH_VCCINT  = 5'd1;
  localparam logic [4:0] CH_VCCAUX  = 5'd2;
  localparam logic [4:0] CH_VPVN    = 5'd3;
  localparam logic [4:0] CH_VCCBRAM = 5'd6;
  localparam logic [4:0] CH_VCCPINT = 5'd13;
  localparam logic [4:0] CH_VCCPAUX = 5'd14;
  localparam logic [4:0] CH_VCCDDR  = 5'd15;
  localparam logic [4:0] CH_VAUX0   = 5'd16;
  localparam logic [4:0] CH_VAUX1   = 5'd17;
  localparam logic [4:0] CH_VAUX8   = 5'd24;
  localparam logic [4:0] CH_VAUX9   = 5'd25;

  // Configuration registers
  localparam logic [6:0] ADDR_CFG0 = 7'h40;
  localparam logic [6:0] ADDR_CFG1 = 7'h41;
  localparam logic [6:0] ADDR_CFG2 = 7'h42;

  // Status registers live at the low addresses, one per channel
  function automatic logic [6:0] drp_chan_addr(input logic [4:0] chan);
    return {2'b00, chan};
  endfunction

endpackage

// File: rtl/red_pitaya_xadc_drp_ctrl.sv
// XADC DRP owner: arbitrates EOC-triggered readback against single SW DRP accesses.
// Latency: DEN one cycle after grant; sample/done one cycle after DRDY (or after timeout).
// Backpressure: none downstream; EOCs queue in a one-deep slot (overrun flagged), SW holds sw_req_i.
module red_pitaya_xadc_drp_ctrl
  import red_pitaya_xadc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int SMP_BITS    = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                xadc_eoc_i,
  input  logic [4:0]          xadc_chan_i,
  output logic [6:0]          drp_addr_o,
  output logic                drp_en_o,
  output logic                drp_we_o,
  output logic [15:0]         drp_di_o,
  input  logic [15:0]         drp_do_i,
  input  logic                drp_drdy_i,
  input  logic                sw_req_i,
  input  logic                sw_we_i,
  input  logic [6:0]          sw_addr_i,
  input  logic [15:0]         sw_wdata_i,
  output logic                sw_done_o,
  output logic [15:0]         sw_rdata_o,
  output logic                sw_err_o,
  output logic                smp_valid_o,
  output logic [4:0]          smp_chan_o,
  output logic [SMP_BITS-1:0] smp_data_o,
  output logic                ovr_o,
  input  logic                ovr_clr_i
);

  localparam int              CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic [4:0]       r_pend_chan;
  logic             r_last_sw;
  logic [4:0]       r_auto_chan;

  logic       w_idle;
  logic       w_sw_req;
  logic       w_pend_any;
  logic [4:0] w_gnt_chan;
  logic       w_gnt_sw;
  logic       w_gnt_auto;
  logic       w_cnt_max;
  logic       w_ovr_eoc;
  logic       w_ovr_to;

  assign w_idle     = (r_state == ST_IDLE);
  // SW can only react to sw_done_o one cycle later, so a request still
  // high during the done cycle is the finished one, not a new one.
  assign w_sw_req   = sw_req_i & ~sw_done_o;
  // Same-cycle EOC is grantable straight away (zero-wait).
  assign w_pend_any = r_pend | xadc_eoc_i;
  // An already-pending channel is older, so it is served first; a
  // coincident EOC then re-arms the slot instead of being lost.
  assign w_gnt_chan = r_pend ? r_pend_chan : xadc_chan_i;
  // Round-robin on contention: last_sw = 0 favours SW, 1 favours AUTO.
  assign w_gnt_sw   = w_idle & w_sw_req & (~w_pend_any | ~r_last_sw);
  assign w_gnt_auto = w_idle & w_pend_any & ~w_gnt_sw;
  assign w_cnt_max  = (r_cnt == CNT_MAX);
  // Slot overwritten only if its current content is not being granted now.
  assign w_ovr_eoc  = xadc_eoc_i & r_pend & ~w_gnt_auto;
  assign w_ovr_to   = (r_state == ST_AUTO_WAIT) & ~drp_drdy_i & w_cnt_max;

  // Pending EOC slot: set/overwritten by EOC, cleared when an AUTO grant consumes it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend      <= 1'b0;
      r_pend_chan <= 5'd0;
    end else if (xadc_eoc_i && !(w_gnt_auto && !r_pend)) begin
      r_pend      <= 1'b1;
      r_pend_chan <= xadc_chan_i;
    end else if (w_gnt_auto) begin
      r_pend      <= 1'b0;
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovr_o <= 1'b0;
    end else if (w_ovr_eoc || w_ovr_to) begin
      ovr_o <= 1'b1;
    end else if (ovr_clr_i) begin
      ovr_o <= 1'b0;
    end
  end

  // Transaction FSM: grant, issue DEN, wait for DRDY or timeout, report result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_sw   <= 1'b0;
      r_auto_chan <= 5'd0;
      drp_addr_o  <= 7'd0;
      drp_en_o    <= 1'b0;
      drp_we_o    <= 1'b0;
      drp_di_o    <= 16'd0;
      sw_done_o   <= 1'b0;
      sw_rdata_o  <= 16'd0;
      sw_err_o    <= 1'b0;
      smp_valid_o <= 1'b0;
      smp_chan_o  <= 5'd0;
      smp_data_o  <= '0;
    end else begin
      drp_en_o    <= 1'b0;
      drp_we_o    <= 1'b0;
      sw_done_o   <= 1'b0;
      sw_err_o    <= 1'b0;
      smp_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Counter is 0 in the DEN cycle that follows a grant.
          r_cnt <= '0;
          if (w_gnt_sw) begin
            drp_en_o   <= 1'b1;
            drp_we_o   <= sw_we_i;
            drp_addr_o <= sw_addr_i;
            drp_di_o   <= sw_wdata_i;
            r_last_sw  <= 1'b1;
            r_state    <= ST_SW_WAIT;
          end else if (w_gnt_auto) begin
            drp_en_o    <= 1'b1;
            drp_addr_o  <= drp_chan_addr(w_gnt_chan);
            r_auto_chan <= w_gnt_chan;
            r_last_sw   <= 1'b0;
            r_state     <= ST_AUTO_WAIT;
          end
        end
        ST_AUTO_WAIT: begin
          if (drp_drdy_i) begin
            smp_valid_o <= 1'b1;
            smp_chan_o  <= r_auto_chan;
            smp_data_o  <= drp_do_i[15 -: SMP_BITS];
            r_state     <= ST_IDLE;
          end else if (w_cnt_max) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SW_WAIT: begin
          if (drp_drdy_i) begin
            sw_done_o  <= 1'b1;
            sw_rdata_o <= drp_do_i;
            r_state    <= ST_IDLE;
          end else if (w_cnt_max) begin
            sw_done_o  <= 1'b1;
            sw_err_o   <= 1'b1;
            sw_rdata_o <= 16'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_xadc_drp_ctrl.sv
// Directed bench for the XADC DRP controller: readback, SW access, arbitration,
// overrun, timeout and mid-transaction reset, checked with immediate assertions.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_red_pitaya_xadc_drp_ctrl;
  import red_pitaya_xadc_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        xadc_eoc_i;
  logic [4:0]  xadc_chan_i;
  logic [6:0]  drp_addr_o;
  logic        drp_en_o;
  logic        drp_we_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i;
  logic        drp_drdy_i;
  logic        sw_req_i;
  logic        sw_we_i;
  logic [6:0]  sw_addr_i;
  logic [15:0] sw_wdata_i;
  logic        sw_done_o;
  logic [15:0] sw_rdata_o;
  logic        sw_err_o;
  logic        smp_valid_o;
  logic [4:0]  smp_chan_o;
  logic [11:0] smp_data_o;
  logic        ovr_o;
  logic        ovr_clr_i;

  int n_pass = 0;
  int n_tot  = 0;

  red_pitaya_xadc_drp_ctrl #(.TIMEOUT_CYC(64), .SMP_BITS(12)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .xadc_eoc_i  (xadc_eoc_i),
    .xadc_chan_i (xadc_chan_i),
    .drp_addr_o  (drp_addr_o),
    .drp_en_o    (drp_en_o),
    .drp_we_o    (drp_we_o),
    .drp_di_o    (drp_di_o),
    .drp_do_i    (drp_do_i),
    .drp_drdy_i  (drp_drdy_i),
    .sw_req_i    (sw_req_i),
    .sw_we_i     (sw_we_i),
    .sw_addr_i   (sw_addr_i),
    .sw_wdata_i  (sw_wdata_i),
    .sw_done_o   (sw_done_o),
    .sw_rdata_o  (sw_rdata_o),
    .sw_err_o    (sw_err_o),
    .smp_valid_o (smp_valid_o),
    .smp_chan_o  (smp_chan_o),
    .smp_data_o  (smp_data_o),
    .ovr_o       (ovr_o),
    .ovr_clr_i   (ovr_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock; land just after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".addr"},  32'(drp_addr_o),  0);
    chk({tag, ".en"},    32'(drp_en_o),    0);
    chk({tag, ".we"},    32'(drp_we_o),    0);
    chk({tag, ".di"},    32'(drp_di_o),    0);
    chk({tag, ".done"},  32'(sw_done_o),   0);
    chk({tag, ".rdata"}, 32'(sw_rdata_o),  0);
    chk({tag, ".err"},   32'(sw_err_o),    0);
    chk({tag, ".valid"}, 32'(smp_valid_o), 0);
    chk({tag, ".chan"},  32'(smp_chan_o),  0);
    chk({tag, ".data"},  32'(smp_data_o),  0);
    chk({tag, ".ovr"},   32'(ovr_o),       0);
  endtask

  // Called in the DEN cycle: assert DRDY 'dly' cycles later with data 'd',
  // return in the cycle where the result is visible.
  task automatic drp_resp(input int dly, input logic [15:0] d);
    repeat (dly) tick();
    drp_drdy_i = 1'b1;
    drp_do_i   = d;
    tick();
    drp_drdy_i = 1'b0;
  endtask

  // Safety net in case the sequence itself gets stuck
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1; xadc_eoc_i = 1'b0; xadc_chan_i = 5'd0;
    drp_do_i = 16'd0; drp_drdy_i = 1'b0;
    sw_req_i = 1'b0; sw_we_i = 1'b0; sw_addr_i = 7'd0; sw_wdata_i = 16'd0;
    ovr_clr_i = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // 1: EOC on VAUX8, zero-wait grant, DRDY 3 cycles after DEN
    xadc_eoc_i = 1'b1; xadc_chan_i = CH_VAUX8;
    tick();
    xadc_eoc_i = 1'b0;
    chk("t1.den",  32'(drp_en_o),   1);
    chk("t1.addr", 32'(drp_addr_o), 32'h18);
    chk("t1.we",   32'(drp_we_o),   0);
    drp_resp(3, 16'hABC0);
    chk("t1.valid", 32'(smp_valid_o), 1);
    chk("t1.chan",  32'(smp_chan_o),  24);
    chk("t1.data",  32'(smp_data_o),  32'hABC);
    chk("t1.ovr",   32'(ovr_o),       0);
    tick();
    chk("t1.valid_pulse", 32'(smp_valid_o), 0);

    // 3: EOC and SW request together with last_sw = 0 -> SW first, then AUTO
    xadc_eoc_i = 1'b1; xadc_chan_i = CH_VAUX0;
    sw_req_i = 1'b1; sw_we_i = 1'b0; sw_addr_i = ADDR_CFG2;
    tick();
    xadc_eoc_i = 1'b0;
    chk("t3.sw_den",  32'(drp_en_o),   1);
    chk("t3.sw_addr", 32'(drp_addr_o), 32'h42);
    drp_resp(1, 16'h1234);
    chk("t3.sw_done",  32'(sw_done_o),  1);
    chk("t3.sw_rdata", 32'(sw_rdata_o), 32'h1234);
    tick();
    sw_req_i = 1'b0;
    chk("t3.auto_den",  32'(drp_en_o),   1);
    chk("t3.auto_addr", 32'(drp_addr_o), 32'd16);
    drp_resp(0, 16'h5550);
    chk("t3.auto_chan", 32'(smp_chan_o), 16);
    chk("t3.auto_data", 32'(smp_data_o), 32'h555);

    // 2: SW read of CFG1
    tick();
    sw_req_i = 1'b1; sw_we_i = 1'b0; sw_addr_i = ADDR_CFG1;
    tick();
    chk("t2.den",  32'(drp_en_o),   1);
    chk("t2.addr", 32'(drp_addr_o), 32'h41);
    chk("t2.we",   32'(drp_we_o),   0);
    drp_resp(2, 16'h2F0F);
    chk("t2.done",  32'(sw_done_o),  1);
    chk("t2.rdata", 32'(sw_rdata_o), 32'h2F0F);
    chk("t2.err",   32'(sw_err_o),   0);
    // Request still high during the done cycle must not re-issue
    tick();
    chk("t2.no_reissue", 32'(drp_en_o), 0);
    chk("t2.done_pulse", 32'(sw_done_o), 0);
    // Next contention follows a SW grant -> AUTO wins
    xadc_eoc_i = 1'b1; xadc_chan_i = CH_VPVN;
    tick();
    xadc_eoc_i = 1'b0;
    chk("t3b.auto_wins", 32'(drp_addr_o), 32'd3);
    chk("t3b.auto_we",   32'(drp_we_o),   0);
    drp_resp(0, 16'hFFF0);
    chk("t3b.data", 32'(smp_data_o), 32'hFFF);
    tick();
    chk("t3b.sw_after", 32'(drp_addr_o), 32'h41);
    chk("t3b.sw_den",   32'(drp_en_o),   1);
    drp_resp(0, 16'h0001);
    chk("t3b.sw_rdata", 32'(sw_rdata_o), 32'h0001);
    sw_req_i = 1'b0;
    tick();

    // 4: two EOCs during one SW_WAIT -> one read of the later channel, overrun
    sw_req_i = 1'b1; sw_we_i = 1'b0; sw_addr_i = ADDR_CFG2;
    tick();
    chk("t4.sw_den", 32'(drp_en_o), 1);
    xadc_eoc_i = 1'b1; xadc_chan_i = CH_VAUX0;
    tick();
    xadc_chan_i = CH_VAUX1;
    tick();
    xadc_eoc_i = 1'b0;
    chk("t4.ovr_set", 32'(ovr_o), 1);
    drp_drdy_i = 1'b1; drp_do_i = 16'h0100;
    tick();
    drp_drdy_i = 1'b0;
    chk("t4.sw_done", 32'(sw_done_o), 1);
    sw_req_i = 1'b0;
    tick();
    chk("t4.auto_den",  32'(drp_en_o),   1);
    chk("t4.auto_addr", 32'(drp_addr_o), 32'd17);
    drp_resp(0, 16'h7770);
    chk("t4.chan", 32'(smp_chan_o), 17);
    chk("t4.data", 32'(smp_data_o), 32'h777);
    tick();
    chk("t4.single_read", 32'(drp_en_o), 0);
    chk("t4.ovr_sticky",  32'(ovr_o),    1);
    ovr_clr_i = 1'b1;
    tick();
    ovr_clr_i = 1'b0;
    chk("t4.ovr_clr", 32'(ovr_o), 0);

    // 5: SW write of CFG0 with no DRDY -> timeout at DEN+64
    sw_req_i = 1'b1; sw_we_i = 1'b1; sw_addr_i = ADDR_CFG0; sw_wdata_i = 16'h0000;
    tick();
    chk("t5.den",  32'(drp_en_o),   1);
    chk("t5.we",   32'(drp_we_o),   1);
    chk("t5.addr", 32'(drp_addr_o), 32'h40);
    chk("t5.di",   32'(drp_di_o),   0);
    n = 0;
    while (!sw_done_o && n < 100) begin
      tick();
      n++;
    end
    chk("t5.latency", 32'(n),          64);
    chk("t5.done",    32'(sw_done_o),  1);
    chk("t5.err",     32'(sw_err_o),   1);
    chk("t5.rdata",   32'(sw_rdata_o), 0);
    chk("t5.no_ovr",  32'(ovr_o),      0);
    sw_req_i = 1'b0; sw_we_i = 1'b0;
    tick();
    drp_drdy_i = 1'b1; drp_do_i = 16'h1234;
    tick();
    drp_drdy_i = 1'b0;
    tick();
    chk("t5.stray_done",  32'(sw_done_o),   0);
    chk("t5.stray_valid", 32'(smp_valid_o), 0);
    chk("t5.stray_rdata", 32'(sw_rdata_o),  0);
    chk("t5.stray_en",    32'(drp_en_o),    0);

    // 6: reset during AUTO_WAIT with a pending EOC, then a late DRDY
    xadc_eoc_i = 1'b1; xadc_chan_i = CH_VCCAUX;
    tick();
    chk("t6.den", 32'(drp_en_o), 1);
    xadc_chan_i = CH_VAUX9;
    tick();
    xadc_eoc_i = 1'b0;
    rst_i = 1'b1;
    tick();
    chk_all_zero("t6.in_reset");
    rst_i = 1'b0;
    drp_drdy_i = 1'b1; drp_do_i = 16'hABCD;
    tick();
    drp_drdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6.no_den",   32'(drp_en_o),    0);
      chk("t6.no_valid", 32'(smp_valid_o), 0);
      tick();
    end
    chk_all_zero("t6.after");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
